sipo_frame_ctrl: RTL and testbench
==================================

# sipo_frame_ctrl

Sequencing controller for serial-in parallel-out capture. It frames a serial bit stream and counts bits into an internal right-shifting SIPO register (new bit enters at the MSB). It latches each completed word into a holding register and presents the word on a valid/ready output port. It sits between a serial front end (pin synchroniser or deserialiser) and any parallel consumer, and flags overrun and inter-bit timeout errors.

## Interface
- `WIDTH`, default 8: word length in bits; legal range is WIDTH ≥ 2.
- `IDLE_TIMEOUT`, default 16: number of consecutive cycles without `bit_valid` inside a frame that aborts the frame; 0 disables the timeout.
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a new frame.
- `bit_valid`  in  1  qualifies `bit_in` this cycle.
- `bit_in`  in  1  serial data, LSB first.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_data`  out  WIDTH  latched word.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `busy`  out  1  frame in progress (state SHIFT).
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `timeout_err`  out  1  one-cycle pulse: frame aborted by timeout.

## Operation
- There are two states, IDLE and SHIFT. `busy` = (state == SHIFT).
- **Reset:** state goes to IDLE. The shift register, bit counter, timer and `out_data` are all cleared to 0. `out_valid`, `overrun` and `timeout_err` are 0.
- **IDLE:**
  - `bit_valid` is ignored.
  - `start` moves the block to SHIFT and clears the shift register, bit counter (width `$clog2(WIDTH)`) and timer.
  - A `bit_valid` in the same cycle as `start` is discarded.
- **SHIFT, on `bit_valid`:**
  - The shift register loads `{bit_in, shreg[WIDTH-1:1]}`.
  - The counter increments and the timer clears.
  - The first received bit ends up in bit 0 of the finished word.
- **Frame complete** (`bit_valid` while counter == WIDTH-1):
  - The next shift-register value, including this bit, is the completed word.
  - State returns to IDLE and the counter returns to 0.
  - If the holding register is free, it loads the word and `out_valid` is 1 next cycle. "Free" means `out_valid` is 0, or `out_valid && out_ready` in this same cycle.
  - Otherwise the word is dropped, `out_data` is unchanged, and `overrun` pulses high next cycle.
- **`start` while in SHIFT:**
  - The frame restarts: shift register, counter and timer clear, and the state stays SHIFT.
  - Any `bit_valid` in that cycle is discarded. No error is flagged.
  - `start` has priority over frame completion and over timeout.
- **Timeout** (IDLE_TIMEOUT > 0):
  - The timer (width `$clog2(IDLE_TIMEOUT+1)`) increments on each SHIFT cycle without `bit_valid`.
  - When the timer == IDLE_TIMEOUT-1 and `bit_valid` is 0, the block moves to IDLE and `timeout_err` pulses next cycle.
  - The partial word is discarded and the holding register is untouched.
  - The timer saturates and never wraps.
- **Output handshake:**
  - `out_data` is stable while `out_valid` is 1.
  - A transfer occurs when `out_valid && out_ready`. `out_valid` falls next cycle unless a new word loads in the same cycle, in which case `out_valid` stays 1 with the new data.
  - `out_ready` while `out_valid` is 0 has no effect.
- Completion and output drain are independent: a held word and a frame in progress coexist.

## Timing
- Latency from final `bit_valid` to `out_valid` is 1 cycle.
- Peak throughput: start-to-start is WIDTH+1 cycles when `start` follows completion back-to-back (1 cycle `start`, WIDTH bit cycles).
- `start` during the completion cycle is not possible, because completion returns to IDLE. A `start` in the following cycle begins the next frame with no lost cycle.
- `overrun` and `timeout_err` are registered and are high for exactly 1 cycle.
- **Asynchronous reset mid-frame:** the partial word is lost and outputs return to their reset values immediately. The first post-reset edge with `start` begins a clean frame.

## Test plan
- **Reset values:** assert `reset` mid-frame with `out_valid`=1 → all outputs are 0 on the next sample. After release, `busy` stays 0 until `start`.
- **Basic word:** WIDTH=8, `out_ready`=1. Send `start`, then bits 1,0,1,0,0,1,0,1 on consecutive cycles → `out_data`=0xA5 and `out_valid`=1 exactly one cycle after the 8th bit, for one cycle. `busy` is 1 for 8 cycles.
- **Backpressure/overrun:** `out_ready`=0. Send frame 0x3C, then frame 0xC3 → `out_data` stays 0x3C and `overrun` pulses once after the 16th bit. Raising `out_ready` in the same cycle as the second frame's last bit instead loads 0xC3 with `out_valid` held 1 and no `overrun`.
- **Gapped bits/timeout:** IDLE_TIMEOUT=16.
  - 15-cycle gaps between bits → the word completes normally.
  - After 3 bits, hold `bit_valid`=0 for 16 cycles → `timeout_err` pulses, `busy` falls, and `out_valid` is unchanged.
- **Restart:** after 5 bits, pulse `start` together with `bit_valid`; then send 0x81 → `out_data`=0x81 with no error pulses.
- **Idle noise:** `bit_valid` toggling in IDLE without `start` → no state change, `out_valid` stays 0.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sipo_frame_ctrl
//
// Frames a serial bit stream into WIDTH-bit words. Bits arrive LSB first and
// are shifted into a right-shifting register with the new bit entering at the
// MSB. After WIDTH qualified bits, the word is handed to a one-entry holding
// register that drives a valid/ready output port.
//
// The controller reports two error conditions:
//   - overrun: a finished word was dropped because the holding register was
//     still occupied.
//   - timeout: a frame was abandoned because no bit arrived for IDLE_TIMEOUT
//     consecutive cycles.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   i_start         single-cycle pulse; begins or restarts a frame
//   i_bit_valid     qualifies i_bit_in
//   i_bit_in        serial data, LSB first
//   i_out_ready     consumer accepts o_out_data
//   o_out_data      latched word
//   o_out_valid     o_out_data holds an unconsumed word
//   o_busy          frame in progress
//   o_overrun       1-cycle pulse: completed word dropped
//   o_timeout_err   1-cycle pulse: frame aborted by inter-bit timeout
// ---------------------------------------------------------------------------
module sipo_frame_ctrl #(
    parameter int WIDTH        = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_bit_valid,
    input  logic             i_bit_in,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_timeout_err
);

    localparam int CW = $clog2(WIDTH);

    // A disabled timeout still needs a 1-bit timer so the declarations stay legal.
    localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [TW-1:0] TIMER_LAST = (IDLE_TIMEOUT > 0) ? TW'(IDLE_TIMEOUT - 1) : {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_SAT  = (IDLE_TIMEOUT > 0) ? TW'(IDLE_TIMEOUT) : {TW{1'b1}};
    localparam logic          TIMEOUT_EN = (IDLE_TIMEOUT > 0);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [TW-1:0]    r_timer;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_timeout_err;

    logic             w_in_shift;
    logic             w_shift_en;
    logic             w_complete;
    logic             w_timeout;
    logic             w_free;
    logic             w_load;
    logic [WIDTH-1:0] w_shreg_next;

    // Bits are only accepted when no start is present. A start always wins
    // over completion and over timeout, so both are qualified with !i_start.
    assign w_in_shift   = (r_state == ST_SHIFT);
    assign w_shift_en   = w_in_shift && !i_start && i_bit_valid;
    assign w_complete   = w_shift_en && (r_cnt == LAST_BIT);
    assign w_timeout    = TIMEOUT_EN && w_in_shift && !i_start && !i_bit_valid
                          && (r_timer == TIMER_LAST);
    assign w_shreg_next = {i_bit_in, r_shreg[WIDTH-1:1]};

    // The holding register counts as free when it is empty, or when its current
    // word is being consumed on this same edge.
    assign w_free = !r_out_valid || i_out_ready;
    assign w_load = w_complete && w_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_shreg       <= '0;
            r_cnt         <= '0;
            r_timer       <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_overrun     <= w_complete && !w_free;
            r_timeout_err <= w_timeout;

            if (i_start) begin
                r_state <= ST_SHIFT;
                r_shreg <= '0;
                r_cnt   <= '0;
                r_timer <= '0;
            end else if (w_in_shift) begin
                if (i_bit_valid) begin
                    r_shreg <= w_shreg_next;
                    r_timer <= '0;
                    if (r_cnt == LAST_BIT) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else if (w_timeout) begin
                    // The partial word is left in r_shreg. The next start
                    // clears it before it can be used.
                    r_state <= ST_IDLE;
                end else if (r_timer != TIMER_SAT) begin
                    r_timer <= r_timer + 1'b1;
                end
            end

            if (w_load) begin
                r_out_data  <= w_shreg_next;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_data    = r_out_data;
    assign o_out_valid   = r_out_valid;
    assign o_busy        = w_in_shift;
    assign o_overrun     = r_overrun;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sipo_frame_ctrl
//
// Directed testbench for sipo_frame_ctrl with WIDTH=8 and IDLE_TIMEOUT=16.
//
// Stimulus is applied 1 ns after each rising edge, and outputs are sampled at
// the same point. Each sample therefore shows the result of the edge that has
// just occurred.
// ---------------------------------------------------------------------------
module tb_sipo_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start;
    logic       i_bit_valid;
    logic       i_bit_in;
    logic       i_out_ready;
    logic [7:0] o_out_data;
    logic       o_out_valid;
    logic       o_busy;
    logic       o_overrun;
    logic       o_timeout_err;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    int to_cnt   = 0;

    sipo_frame_ctrl #(
        .WIDTH        (8),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_bit_valid   (i_bit_valid),
        .i_bit_in      (i_bit_in),
        .i_out_ready   (i_out_ready),
        .o_out_data    (o_out_data),
        .o_out_valid   (o_out_valid),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun),
        .o_timeout_err (o_timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one cycle and tally any error pulses seen.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (o_overrun)     ovr_cnt++;
        if (o_timeout_err) to_cnt++;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        i_bit_valid = 1'b1;
        i_bit_in    = b;
        cyc();
        i_bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        pulse_start();
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_start = 0; i_bit_valid = 0; i_bit_in = 0; i_out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_out_data, o_out_valid, o_busy, o_overrun, o_timeout_err} !== 12'h000) begin
            failures++;
            $display("FAIL reset_values got=%h want=000",
                     {o_out_data, o_out_valid, o_busy, o_overrun, o_timeout_err});
        end
        reset = 1'b0;
        cyc(); cyc();
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_release got=%b want=0", o_busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int busy_cnt;
        logic [7:0] w;
        w = 8'hA5;
        i_out_ready = 1'b1;
        pulse_start();
        busy_cnt = int'(o_busy);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i]);
            if (i < 7) busy_cnt += int'(o_busy);
        end
        checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'hA5) begin
            failures++;
            $display("FAIL basic_word got valid=%b data=%h want valid=1 data=a5", o_out_valid, o_out_data);
        end
        checks++;
        if (busy_cnt != 8 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy got cycles=%0d busy_now=%b want cycles=8 busy_now=0", busy_cnt, o_busy);
        end
        cyc();
        checks++;
        if (o_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_one_cycle got=%b want=0", o_out_valid);
        end
        $display("test_basic word=%h", o_out_data);
    endtask

    task automatic test_back_to_back();
        i_out_ready = 1'b1;
        send_word(8'h96);
        checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h96) begin
            failures++;
            $display("FAIL b2b_first got valid=%b data=%h want valid=1 data=96", o_out_valid, o_out_data);
        end
        send_word(8'h69);
        checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h69) begin
            failures++;
            $display("FAIL b2b_second got valid=%b data=%h want valid=1 data=69", o_out_valid, o_out_data);
        end
        cyc();
        $display("test_back_to_back done");
    endtask

    task automatic test_overrun();
        logic [7:0] w;
        i_out_ready = 1'b0;
        ovr_cnt = 0;
        send_word(8'h3C);
        w = 8'hC3;
        send_word(w);
        checks++;
        if (o_overrun !== 1'b1 || o_out_data !== 8'h3C || o_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_drop got ovr=%b data=%h valid=%b want ovr=1 data=3c valid=1",
                     o_overrun, o_out_data, o_out_valid);
        end
        cyc();
        checks++;
        if (ovr_cnt != 1 || o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_single_pulse got pulses=%0d now=%b want pulses=1 now=0", ovr_cnt, o_overrun);
        end

        // Draining and refilling on the same edge keeps valid high and
        // reports no overrun.
        ovr_cnt = 0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) i_out_ready = 1'b1;
            send_bit(w[i]);
        end
        i_out_ready = 1'b0;
        checks++;
        if (o_out_data !== 8'hC3 || o_out_valid !== 1'b1 || ovr_cnt != 0) begin
            failures++;
            $display("FAIL overrun_same_cycle_drain got data=%h valid=%b pulses=%0d want data=c3 valid=1 pulses=0",
                     o_out_data, o_out_valid, ovr_cnt);
        end
        i_out_ready = 1'b1;
        cyc();
        checks++;
        if (o_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_drain got valid=%b want=0", o_out_valid);
        end
        $display("test_overrun done");
    endtask

    task automatic test_gapped();
        logic [7:0] w;
        logic       busy_before_last;
        w = 8'h5A;
        i_out_ready = 1'b1;
        to_cnt = 0;
        busy_before_last = 1'b0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                repeat (15) cyc();
            end
            if (i == 7) busy_before_last = o_busy;
            send_bit(w[i]);
        end
        checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h5A || to_cnt != 0 || busy_before_last !== 1'b1) begin
            failures++;
            $display("FAIL gapped_word got valid=%b data=%h to=%0d busy=%b want valid=1 data=5a to=0 busy=1",
                     o_out_valid, o_out_data, to_cnt, busy_before_last);
        end
        cyc();
        $display("test_gapped done");
    endtask

    task automatic test_timeout();
        i_out_ready = 1'b0;
        send_word(8'h11);
        to_cnt = 0;
        pulse_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (15) cyc();
        checks++;
        if (o_busy !== 1'b1 || to_cnt != 0) begin
            failures++;
            $display("FAIL timeout_early got busy=%b to=%0d want busy=1 to=0", o_busy, to_cnt);
        end
        cyc();
        checks++;
        if (o_timeout_err !== 1'b1 || o_busy !== 1'b0 || o_out_valid !== 1'b1 || o_out_data !== 8'h11) begin
            failures++;
            $display("FAIL timeout_fire got to=%b busy=%b valid=%b data=%h want to=1 busy=0 valid=1 data=11",
                     o_timeout_err, o_busy, o_out_valid, o_out_data);
        end
        cyc();
        checks++;
        if (o_timeout_err !== 1'b0 || to_cnt != 1) begin
            failures++;
            $display("FAIL timeout_pulse got now=%b pulses=%0d want now=0 pulses=1", o_timeout_err, to_cnt);
        end
        i_out_ready = 1'b1;
        cyc();
        $display("test_timeout done");
    endtask

    task automatic test_restart();
        logic [7:0] w;
        w = 8'h81;
        i_out_ready = 1'b1;
        ovr_cnt = 0;
        to_cnt = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        i_start = 1'b1; i_bit_valid = 1'b1; i_bit_in = 1'b1;
        cyc();
        i_start = 1'b0; i_bit_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_busy got=%b want=1", o_busy);
        end
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        checks++;
        if (o_out_data !== 8'h81 || o_out_valid !== 1'b1 || ovr_cnt != 0 || to_cnt != 0) begin
            failures++;
            $display("FAIL restart_word got data=%h valid=%b ovr=%0d to=%0d want data=81 valid=1 ovr=0 to=0",
                     o_out_data, o_out_valid, ovr_cnt, to_cnt);
        end
        cyc();
        $display("test_restart done");
    endtask

    task automatic test_idle_noise();
        int bad;
        bad = 0;
        i_out_ready = 1'b1;
        cyc();
        for (int i = 0; i < 12; i++) begin
            i_bit_valid = i[0];
            i_bit_in    = 1'($urandom_range(0, 1));
            cyc();
            if (o_busy !== 1'b0 || o_out_valid !== 1'b0) bad++;
        end
        i_bit_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_noise got bad_cycles=%0d want=0", bad);
        end
        $display("test_idle_noise done");
    endtask

    task automatic test_reset_mid_frame();
        i_out_ready = 1'b0;
        send_word(8'hF0);
        pulse_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({o_out_data, o_out_valid, o_busy, o_overrun, o_timeout_err} !== 12'h000) begin
            failures++;
            $display("FAIL reset_async got=%h want=000",
                     {o_out_data, o_out_valid, o_busy, o_overrun, o_timeout_err});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(); cyc();
        checks++;
        if (o_busy !== 1'b0 || o_out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_release got busy=%b data=%h want busy=0 data=00", o_busy, o_out_data);
        end
        i_out_ready = 1'b1;
        send_word(8'h42);
        checks++;
        if (o_out_data !== 8'h42 || o_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_clean_frame got data=%h valid=%b want data=42 valid=1", o_out_data, o_out_valid);
        end
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_gapped();
        test_timeout();
        test_restart();
        test_idle_noise();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
